// File: rtl/hdmi_audio_sample_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : hdmi_audio_sample_scheduler                                  |
// | Brief   : Fractional-N audio sample strobe generator, stereo sample    |
// |           FIFO and burst grant logic for the HDMI audio packetizer.    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module hdmi_audio_sample_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_W      = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [ACC_W-1:0]              cfg_num,
  input  logic [ACC_W-1:0]              cfg_den,
  input  logic                          cfg_load,
  output logic                          cfg_err,
  output logic                          audio_sample,
  input  logic [15:0]                   in_l,
  input  logic [15:0]                   in_r,
  input  logic                          pkt_req,
  output logic                          pkt_grant,
  output logic [2:0]                    pkt_count,
  input  logic                          pop,
  output logic [15:0]                   head_l,
  output logic [15:0]                   head_r,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  localparam int                ADDR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // Active ratio, accumulator and strobe/capture delay line
  logic [ACC_W-1:0] num_q, den_q, acc_q, acc_d;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_wrap;
  logic             w_tick;
  logic             strobe_q, wr1_q, wr2_q;

  // FIFO storage and pointers (one extra bit to tell full from empty)
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [ADDR_W:0]   wptr_q, rptr_q;
  logic [ADDR_W-1:0] w_rnext_idx;
  logic [31:0]       w_wdata, head_q, head_d;
  logic              w_empty, w_full, w_push, w_pop;
  logic              ovf_q;

  // Burst FSM
  state_t   state_q, state_d;
  logic [2:0] count_q, count_d, pops_q, pops_d;

  assign cfg_err = (num_q == '0) || (num_q >= den_q);
  // acc < den guarantees the carry-free sum fits in ACC_W+1 bits; the wrapped
  // value is below den so the ACC_W-bit modular subtraction is exact.
  assign w_sum  = {1'b0, acc_q} + {1'b0, num_q};
  assign w_wrap = acc_q + num_q - den_q;

  // Accumulator next state and tick; a config load restarts the phase
  always_comb begin
    acc_d  = acc_q;
    w_tick = 1'b0;
    if (cfg_load) begin
      acc_d = '0;
    end else if (enable && !cfg_err) begin
      if (w_sum >= {1'b0, den_q}) begin
        acc_d  = w_wrap;
        w_tick = 1'b1;
      end else begin
        acc_d = w_sum[ACC_W-1:0];
      end
    end
  end

  // Ratio registers, accumulator and the strobe -> write-enable delay line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_q    <= '0;
      den_q    <= ACC_W'(1);
      acc_q    <= '0;
      strobe_q <= 1'b0;
      wr1_q    <= 1'b0;
      wr2_q    <= 1'b0;
    end else begin
      if (cfg_load) begin
        num_q <= cfg_num;
        den_q <= cfg_den;
      end
      acc_q    <= acc_d;
      strobe_q <= w_tick;
      wr1_q    <= strobe_q;
      wr2_q    <= wr1_q;
    end
  end

  assign audio_sample = strobe_q;

  assign fifo_level  = wptr_q - rptr_q;
  assign w_empty     = (fifo_level == '0);
  assign w_full      = (fifo_level == FULL_LEVEL);
  assign w_pop       = pop && (state_q == S_GRANT) && !w_empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign w_push      = wr2_q && (!w_full || w_pop);
  assign w_wdata     = {in_l, in_r};
  assign w_rnext_idx = rptr_q[ADDR_W-1:0] + ADDR_W'(1);

  // Head register: reload on pop or on a push into an empty FIFO, else hold
  always_comb begin
    head_d = head_q;
    if (w_pop) begin
      if (fifo_level > (ADDR_W+1)'(1)) begin
        head_d = mem_q[w_rnext_idx];
      end else if (w_push) begin
        head_d = w_wdata;
      end
    end else if (w_push && w_empty) begin
      head_d = w_wdata;
    end
  end

  // Sample storage write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= w_wdata;
    end
  end

  // Pointers, head data and sticky overflow (a new drop beats clear_ovf)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (w_push) wptr_q <= wptr_q + (ADDR_W+1)'(1);
      if (w_pop)  rptr_q <= rptr_q + (ADDR_W+1)'(1);
      head_q <= head_d;
      if (wr2_q && !w_push) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign head_l   = head_q[31:16];
  assign head_r   = head_q[15:0];
  assign overflow = ovf_q;

  // Burst FSM next state: latch burst size on grant, count pops, abort on req drop
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pops_d  = pops_q;
    case (state_q)
      S_IDLE: begin
        if (pkt_req && !w_empty) begin
          state_d = S_GRANT;
          count_d = (fifo_level >= (ADDR_W+1)'(4)) ? 3'd4 : fifo_level[2:0];
          pops_d  = 3'd0;
        end
      end
      S_GRANT: begin
        if (w_pop) pops_d = pops_q + 3'd1;
        if ((pops_d == count_q) || !pkt_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= 3'd0;
      pops_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pops_q  <= pops_d;
    end
  end

  assign pkt_grant = (state_q == S_GRANT);
  assign pkt_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_audio_sample_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_hdmi_audio_sample_scheduler                               |
// | Brief   : Directed self-checking bench for the audio sample scheduler. |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_hdmi_audio_sample_scheduler;

  localparam int ACC_W = 24;

  logic              clk, reset_n, enable, cfg_load, cfg_err, audio_sample;
  logic              pkt_req, pkt_grant, pop, overflow, clear_ovf;
  logic [ACC_W-1:0]  cfg_num, cfg_den;
  logic [15:0]       in_l, in_r, head_l, head_r;
  logic [2:0]        pkt_count;
  logic [3:0]        fifo_level;

  int checks   = 0;
  int failures = 0;
  int rs_ctr   = 0;

  typedef struct {
    logic [ACC_W-1:0] num;
    logic [ACC_W-1:0] den;
    int               cycles;
    logic             exp_err;
    int               exp_strobes;
  } vec_t;

  vec_t vecs [9];

  hdmi_audio_sample_scheduler #(.FIFO_DEPTH(8), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_num      (cfg_num),
    .cfg_den      (cfg_den),
    .cfg_load     (cfg_load),
    .cfg_err      (cfg_err),
    .audio_sample (audio_sample),
    .in_l         (in_l),
    .in_r         (in_r),
    .pkt_req      (pkt_req),
    .pkt_grant    (pkt_grant),
    .pkt_count    (pkt_count),
    .pop          (pop),
    .head_l       (head_l),
    .head_r       (head_r),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #8_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pair(input int v);
    logic [15:0] x;
    x = v[15:0];
    return {x, x ^ 16'hA5A5};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rs_ctr  = 0;
    @(negedge clk);
  endtask

  task automatic load_cfg(input logic [ACC_W-1:0] n, input logic [ACC_W-1:0] d);
    cfg_num  = n;
    cfg_den  = d;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Enable until the next strobe, then act as the restrober for it
  task automatic wait_strobe(output int k);
    k = -1;
    enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (audio_sample) begin
        k = c;
        break;
      end
    end
    enable = 1'b0;
    if (k < 0) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout: actual=none required=pulse within 40 cycles");
    end else begin
      in_l = rs_ctr[15:0];
      in_r = rs_ctr[15:0] ^ 16'hA5A5;
      rs_ctr++;
    end
  endtask

  task automatic gen_strobes(input int n);
    int k;
    for (int i = 0; i < n; i++) wait_strobe(k);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop1();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    int k, cnt, last, sp, min_sp, max_sp, v;
    int exp_heads [7];

    vecs[0] = '{num: 24'd1,       den: 24'd4,        cycles: 20, exp_err: 1'b0, exp_strobes: 5};
    vecs[1] = '{num: 24'd3,       den: 24'd10,       cycles: 20, exp_err: 1'b0, exp_strobes: 6};
    vecs[2] = '{num: 24'd6,       den: 24'd7,        cycles: 14, exp_err: 1'b0, exp_strobes: 12};
    vecs[3] = '{num: 24'd5,       den: 24'd8,        cycles: 16, exp_err: 1'b0, exp_strobes: 10};
    vecs[4] = '{num: 24'd0,       den: 24'd5,        cycles: 20, exp_err: 1'b1, exp_strobes: 0};
    vecs[5] = '{num: 24'd7,       den: 24'd7,        cycles: 20, exp_err: 1'b1, exp_strobes: 0};
    vecs[6] = '{num: 24'd9,       den: 24'd7,        cycles: 20, exp_err: 1'b1, exp_strobes: 0};
    vecs[7] = '{num: 24'd1,       den: 24'hFFFFFF,   cycles: 20, exp_err: 1'b0, exp_strobes: 0};
    vecs[8] = '{num: 24'h800000,  den: 24'hFFFFFF,   cycles: 10, exp_err: 1'b0, exp_strobes: 5};

    reset_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; cfg_num = '0; cfg_den = '0;
    in_l = '0; in_r = '0; pkt_req = 1'b0; pop = 1'b0; clear_ovf = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_audio_sample", 32'(audio_sample), 32'd0);
    chk("rst_pkt_grant",    32'(pkt_grant),    32'd0);
    chk("rst_pkt_count",    32'(pkt_count),    32'd0);
    chk("rst_head",         {head_l, head_r},  32'd0);
    chk("rst_fifo_level",   32'(fifo_level),   32'd0);
    chk("rst_overflow",     32'(overflow),     32'd0);
    chk("rst_cfg_err",      32'(cfg_err),      32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Ratio table: strobe count over a fixed window after a fresh load
    for (int i = 0; i < 9; i++) begin
      enable = 1'b0;
      load_cfg(vecs[i].num, vecs[i].den);
      chk($sformatf("vec%0d_cfg_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
      enable = 1'b1;
      cnt = 0;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(negedge clk);
        if (audio_sample) cnt++;
      end
      enable = 1'b0;
      @(negedge clk);
      if (audio_sample) cnt++;
      chk($sformatf("vec%0d_strobes", i), 32'(cnt), 32'(vecs[i].exp_strobes));
    end

    // Strobe and capture latency from a fresh 1/4 ratio
    do_reset();
    load_cfg(24'd1, 24'd4);
    wait_strobe(k);
    chk("first_strobe_cycle", 32'(k), 32'd4);
    @(negedge clk);
    chk("strobe_one_cycle", 32'(audio_sample), 32'd0);
    @(negedge clk);
    chk("level_before_write", 32'(fifo_level), 32'd0);
    @(negedge clk);
    chk("level_after_write", 32'(fifo_level), 32'd1);
    chk("head_after_write",  {head_l, head_r}, pair(0));

    // Burst of four out of six, then the remaining two
    gen_strobes(5);
    chk("burst_level6", 32'(fifo_level), 32'd6);
    pkt_req = 1'b1;
    @(negedge clk);
    chk("burst_grant", 32'(pkt_grant), 32'd1);
    chk("burst_count4", 32'(pkt_count), 32'd4);
    chk("burst_head0", {head_l, head_r}, pair(0));
    for (int p = 1; p <= 4; p++) begin
      pop1();
      chk($sformatf("burst_head_after_pop%0d", p), {head_l, head_r}, pair(p));
    end
    chk("burst_grant_drop", 32'(pkt_grant), 32'd0);
    chk("burst_level2", 32'(fifo_level), 32'd2);
    @(negedge clk);
    chk("burst2_grant", 32'(pkt_grant), 32'd1);
    chk("burst2_count2", 32'(pkt_count), 32'd2);
    pop1();
    pop1();
    chk("burst2_level0", 32'(fifo_level), 32'd0);
    chk("burst2_head_hold", {head_l, head_r}, pair(5));
    chk("burst2_grant_drop", 32'(pkt_grant), 32'd0);
    pkt_req = 1'b0;

    // Abort after one pop of three
    gen_strobes(3);
    pkt_req = 1'b1;
    @(negedge clk);
    chk("abort_count3", 32'(pkt_count), 32'd3);
    pop1();
    chk("abort_head_entry1", {head_l, head_r}, pair(7));
    pkt_req = 1'b0;
    @(negedge clk);
    chk("abort_grant_drop", 32'(pkt_grant), 32'd0);
    pop1();
    chk("idle_pop_ignored_level", 32'(fifo_level), 32'd2);
    chk("idle_pop_ignored_head",  {head_l, head_r}, pair(7));

    // Reset in the middle of a burst acts without waiting for a clock
    pkt_req = 1'b1;
    @(negedge clk);
    chk("midrst_grant_before", 32'(pkt_grant), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(pkt_grant), 32'd0);
    chk("midrst_count", 32'(pkt_count), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_head",  {head_l, head_r}, 32'd0);
    chk("midrst_cfg_err", 32'(cfg_err), 32'd1);
    pkt_req = 1'b0;
    do_reset();

    // Overflow: nine strobes into eight slots
    load_cfg(24'd1, 24'd4);
    gen_strobes(9);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level8", 32'(fifo_level), 32'd8);
    chk("ovf_head0", {head_l, head_r}, pair(0));
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // clear_ovf coincident with a dropped write: set wins
    wait_strobe(k);
    @(negedge clk);
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;

    // Push and pop in the same cycle at full
    pkt_req = 1'b1;
    @(negedge clk);
    chk("full_count4", 32'(pkt_count), 32'd4);
    v = rs_ctr;
    wait_strobe(k);
    @(negedge clk);
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    chk("full_pushpop_level", 32'(fifo_level), 32'd8);
    chk("full_pushpop_ovf",   32'(overflow),   32'd0);
    chk("full_pushpop_head",  {head_l, head_r}, pair(1));
    exp_heads = '{2, 3, 4, 5, 6, 7, v};
    for (int p = 0; p < 3; p++) begin
      pop1();
      chk($sformatf("drain_a_head%0d", p), {head_l, head_r}, pair(exp_heads[p]));
    end
    chk("drain_a_grant_drop", 32'(pkt_grant), 32'd0);
    @(negedge clk);
    chk("drain_b_count4", 32'(pkt_count), 32'd4);
    for (int p = 3; p < 7; p++) begin
      pop1();
      chk($sformatf("drain_b_head%0d", p), {head_l, head_r}, pair(exp_heads[p]));
    end
    chk("drain_b_level1", 32'(fifo_level), 32'd1);
    pkt_req = 1'b0;
    @(negedge clk);

    // Long-run rate: 48 kHz from 27 MHz over 54000 cycles
    load_cfg(24'd48, 24'd27000);
    enable = 1'b1;
    cnt = 0; last = -1; min_sp = 1_000_000; max_sp = 0;
    for (int c = 1; c <= 54000; c++) begin
      @(negedge clk);
      if (audio_sample) begin
        cnt++;
        if (last >= 0) begin
          sp = c - last;
          if (sp < min_sp) min_sp = sp;
          if (sp > max_sp) max_sp = sp;
        end
        last = c;
      end
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("rate_count",   32'(cnt),    32'd96);
    chk("rate_min_gap", 32'(min_sp), 32'd562);
    chk("rate_max_gap", 32'(max_sp), 32'd563);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmi_audio_sample_scheduler.md
# hdmi_audio_sample_scheduler

Generates the audio sample strobe for the HDMI audio clock-domain transfer stage and buffers the returned stereo samples for the HDMI audio packetizer. A fractional-N accumulator derives an average rate of fs strobes per second from the pixel clock. Each strobe's captured L/R pair is pushed into a small FIFO. The block grants the packetizer bursts of up to 4 samples per audio sample packet. It sits entirely in the HDMI pixel-clock domain, between the restrober and the data-island packet builder.

## Interface
- `FIFO_DEPTH`, default 8: sample FIFO depth; must be a power of 2, ≥ 4.
- `ACC_W`, default 24: accumulator and ratio width.
- `clk`, in, 1: HDMI pixel clock; the only clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: strobe generation enable; 0 holds the accumulator and suppresses ticks.
- `cfg_num`, in, ACC_W: sample rate numerator (fs, scaled).
- `cfg_den`, in, ACC_W: pixel clock denominator (f_pix, same scale).
- `cfg_load`, in, 1: one-cycle pulse that loads `cfg_num`/`cfg_den` into the active registers.
- `cfg_err`, out, 1: active ratio invalid (`num == 0` or `num >= den`).
- `audio_sample`, out, 1: one-cycle sample strobe to the restrober.
- `in_l`, `in_r`, in, 16 each: restrober outputs (pixel-clock domain).
- `pkt_req`, in, 1: packetizer has a data-island slot; held high through the burst.
- `pkt_grant`, out, 1: a burst is in progress.
- `pkt_count`, out, 3: burst length (1..4); valid while `pkt_grant` is high.
- `pop`, in, 1: one-cycle pulse that consumes the FIFO head.
- `head_l`, `head_r`, out, 16 each: FIFO head sample (registered FIFO read data).
- `fifo_level`, out, log2(FIFO_DEPTH)+1: current occupancy.
- `overflow`, out, 1: sticky; set when a sample is dropped.
- `clear_ovf`, in, 1: pulse that clears `overflow`.

## Operation
- **Active ratio registers.**
  - Reset values: `num = 0`, `den = 1`, so `cfg_err = 1` and no ticks until configured.
  - `cfg_load` copies the inputs, clears the accumulator to 0, and suppresses any tick in that cycle.
- **Accumulator.** Each cycle with `enable=1` and `cfg_err=0`:
  - if `acc + num >= den`: `acc <= acc + num - den` and `tick = 1`;
  - otherwise `acc <= acc + num`.
  - Compute the sum at ACC_W+1 bits; no wrap is possible because `acc < den`.
- **Strobe.** `audio_sample` is `tick` registered, so it pulses in the cycle after the tick.
- **Capture.** A two-stage delay of `audio_sample` produces `wr_en` two cycles after the strobe, when the restrober output is stable. On `wr_en`, push `{in_l, in_r}`. If the FIFO is full, drop the sample, set `overflow`, and leave the FIFO unchanged.
- **Burst FSM:**
  - IDLE: if `pkt_req && level > 0`, go to GRANT, latch `pkt_count = min(level, 4)`, and clear the pop counter.
  - GRANT: `pkt_grant = 1`. Each `pop` with a non-empty FIFO dequeues one entry and increments the pop counter. When the counter reaches `pkt_count`, return to IDLE. If `pkt_req` drops first, abort to IDLE; unpopped samples stay queued.
  - `pop` outside GRANT, or with the FIFO empty, is ignored.
- **Read data.** `head_l`/`head_r` update the cycle after any push into an empty FIFO or any pop. They hold their last value when the FIFO is empty (zero after reset).
- **Simultaneous push and pop:** level unchanged, both take effect. Push to a full FIFO in the same cycle as a pop: the pop frees a slot and the push succeeds with no overflow.
- **Overflow flag.** `clear_ovf` and a new overflow in the same cycle: `overflow` stays 1 (set wins).
- **`enable` deassert:** the accumulator freezes. Pending `wr_en` stages still complete, and the FSM and FIFO keep operating.

## Timing
- **Reset values (async, `reset_n=0`):** `audio_sample=0`, `pkt_grant=0`, `pkt_count=0`, `head_l=head_r=0`, `fifo_level=0`, `overflow=0`, `cfg_err=1`, accumulator 0, FSM IDLE, delay stages cleared.
- **Latency:**
  - tick (cycle T) to `audio_sample` high: T+1.
  - FIFO write on the edge ending T+3; `fifo_level` increments in T+4.
  - `pkt_req` with level > 0 sampled at T to `pkt_grant`: T+1.
- **Rates.** Minimum strobe spacing is `floor(den/num)` cycles; average rate is exactly `num/den` per cycle.
- **Reset mid-burst** (`reset_n` low) discards FIFO contents and drops `pkt_grant` immediately. A `cfg_load` mid-burst does not affect the FSM or FIFO.

## Test plan
- **Rate:** `num=48`, `den=27000` (27 MHz, 48 kHz) for 1,080,000 cycles -> exactly 1920 `audio_sample` pulses. Each spacing is 562 or 563 cycles.
- **Capture alignment:** model the restrober to update on `audio_sample` with an incrementing counter -> FIFO entries are consecutive values, none skipped or duplicated. `fifo_level` rises 3 cycles after each strobe.
- **Burst:** level 6, `pkt_req` held -> `pkt_count=4`, four pops return entries 0..3, grant drops. A second grant gives `pkt_count=2`.
- **Abort:** grant with `pkt_count=3`, one pop, then `pkt_req` low -> IDLE, level 2 remaining, head is entry 1.
- **Overflow:** no pops, 9 strobes with `FIFO_DEPTH=8` -> `overflow=1`, level 8, entries 0..7 retained. `clear_ovf` clears it. Push and pop in the same cycle at full -> no overflow.
- **Config/reset:** `num=0` -> `cfg_err=1` and no strobes. `cfg_load` to `num=den` -> `cfg_err=1`. `reset_n` low mid-burst -> all outputs at reset values in the same cycle.
